// File: rtl/axis_converter_lite_mc_if.sv
// AXI-Lite slave bus plus the per-channel AXI-Stream pairs of axis_converter_lite_mc.
// Ports (as signals of the interface):
//   AXI-Lite : awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready,
//              araddr/arvalid/arready, rdata/rresp/rvalid/rready
//   Streams  : m_axis_tdata/tvalid/tready (device -> fabric), s_axis_tdata/tvalid/tready
//              (fabric -> device); channel c lives in slice c of each vector.
// Modports: slave = converter side, master = side that drives the AXI-Lite bus and streams.
interface axis_converter_lite_mc_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int N_CH           = 4
);
    logic [AXI_ADDR_WIDTH-1:0]      awaddr;
    logic                           awvalid;
    logic                           awready;
    logic [AXI_DATA_WIDTH-1:0]      wdata;
    logic [AXI_DATA_WIDTH/8-1:0]    wstrb;
    logic                           wvalid;
    logic                           wready;
    logic [1:0]                     bresp;
    logic                           bvalid;
    logic                           bready;
    logic [AXI_ADDR_WIDTH-1:0]      araddr;
    logic                           arvalid;
    logic                           arready;
    logic [AXI_DATA_WIDTH-1:0]      rdata;
    logic [1:0]                     rresp;
    logic                           rvalid;
    logic                           rready;
    logic [N_CH*AXI_DATA_WIDTH-1:0] m_axis_tdata;
    logic [N_CH-1:0]                m_axis_tvalid;
    logic [N_CH-1:0]                m_axis_tready;
    logic [N_CH*AXI_DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_CH-1:0]                s_axis_tvalid;
    logic [N_CH-1:0]                s_axis_tready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
               m_axis_tready, s_axis_tdata, s_axis_tvalid,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               m_axis_tdata, m_axis_tvalid, s_axis_tready
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
               m_axis_tready, s_axis_tdata, s_axis_tvalid,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               m_axis_tdata, m_axis_tvalid, s_axis_tready
    );
endinterface

// File: rtl/axis_converter_lite_mc.sv
// AXI-Lite to multi-channel AXI-Stream converter. Each channel owns a 16-byte register
// block (TX_DATA +0x0, RX_DATA +0x4, STATUS +0x8) backed by a TX FIFO draining to
// m_axis and an RX FIFO filled from s_axis. Both FIFOs are first-word-fall-through.
// Ports:
//   aclk    - single clock
//   aresetn - asynchronous active-low reset
//   bus     - axis_converter_lite_mc_if slave modport (AXI-Lite + N_CH stream pairs)
module axis_converter_lite_mc #(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          N_CH           = 4,
    parameter int          FIFO_DEPTH     = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axis_converter_lite_mc_if.slave        bus
);
    localparam int DW   = AXI_DATA_WIDTH;
    localparam int AW   = AXI_ADDR_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
    localparam logic [AW-1:0] SPAN = AW'(16 * N_CH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [N_CH-1:0] tx_push, tx_pop, tx_full, tx_empty;
    logic [N_CH-1:0] rx_push, rx_pop, rx_full, rx_empty;
    logic [LW-1:0]   tx_level [N_CH];
    logic [LW-1:0]   rx_level [N_CH];
    logic [DW-1:0]   tx_head  [N_CH];
    logic [DW-1:0]   rx_head  [N_CH];

    logic [AW-1:0]   w_off, r_off;
    logic            w_in_map, r_in_map;
    logic [CH_W-1:0] w_ch, r_ch;
    logic [3:0]      w_reg, r_reg;
    logic            w_push_req, r_pop_req;
    logic [1:0]      w_resp, r_resp;
    logic [DW-1:0]   r_data;
    logic [31:0]     status_word;
    logic [1:0]      bresp_q, rresp_q;
    logic [DW-1:0]   rdata_q;
    logic            ready_en;
    logic            unused_bits;

    // Holds s_axis_tready low through reset and releases it on the first clock edge after.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // Per-channel TX and RX FIFOs; level counters give full/empty without pointer tricks.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DW-1:0] tx_mem [FIFO_DEPTH];
        logic [DW-1:0] rx_mem [FIFO_DEPTH];
        logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
        logic [LW-1:0] tx_lvl, rx_lvl;

        assign tx_full[c]  = (tx_lvl == LW'(FIFO_DEPTH));
        assign tx_empty[c] = (tx_lvl == '0);
        assign rx_full[c]  = (rx_lvl == LW'(FIFO_DEPTH));
        assign rx_empty[c] = (rx_lvl == '0);
        assign tx_level[c] = tx_lvl;
        assign rx_level[c] = rx_lvl;
        assign tx_head[c]  = tx_mem[tx_rp];
        assign rx_head[c]  = rx_mem[rx_rp];

        assign tx_push[c] = w_push_req && (w_ch == CH_W'(c)) && !tx_full[c];
        assign tx_pop[c]  = !tx_empty[c] && bus.m_axis_tready[c];
        assign rx_push[c] = bus.s_axis_tvalid[c] && ready_en && !rx_full[c];
        assign rx_pop[c]  = r_pop_req && (r_ch == CH_W'(c)) && !rx_empty[c];

        assign bus.m_axis_tvalid[c] = !tx_empty[c];
        assign bus.s_axis_tready[c] = ready_en && !rx_full[c];

        always_ff @(posedge aclk) begin
            if (tx_push[c]) tx_mem[tx_wp] <= bus.wdata;
            if (rx_push[c]) rx_mem[rx_wp] <= bus.s_axis_tdata[c*DW +: DW];
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                tx_wp  <= '0;
                tx_rp  <= '0;
                tx_lvl <= '0;
                rx_wp  <= '0;
                rx_rp  <= '0;
                rx_lvl <= '0;
            end else begin
                if (tx_push[c]) tx_wp <= tx_wp + 1'b1;
                if (tx_pop[c])  tx_rp <= tx_rp + 1'b1;
                if (rx_push[c]) rx_wp <= rx_wp + 1'b1;
                if (rx_pop[c])  rx_rp <= rx_rp + 1'b1;
                case ({tx_push[c], tx_pop[c]})
                    2'b10:   tx_lvl <= tx_lvl + 1'b1;
                    2'b01:   tx_lvl <= tx_lvl - 1'b1;
                    default: tx_lvl <= tx_lvl;
                endcase
                case ({rx_push[c], rx_pop[c]})
                    2'b10:   rx_lvl <= rx_lvl + 1'b1;
                    2'b01:   rx_lvl <= rx_lvl - 1'b1;
                    default: rx_lvl <= rx_lvl;
                endcase
            end
        end
    end

    always_comb begin
        bus.m_axis_tdata = '0;
        for (int c = 0; c < N_CH; c++) bus.m_axis_tdata[c*DW +: DW] = tx_head[c];
    end

    // Address decode: offset from BASE selects channel (bits above 4) and register (low nibble).
    always_comb begin
        w_off    = bus.awaddr - BASE;
        w_in_map = (bus.awaddr >= BASE) && (w_off < SPAN);
        w_ch     = w_off[4 +: CH_W];
        w_reg    = w_off[3:0];
        r_off    = bus.araddr - BASE;
        r_in_map = (bus.araddr >= BASE) && (r_off < SPAN);
        r_ch     = r_off[4 +: CH_W];
        r_reg    = r_off[3:0];
    end

    // Write response: fullness is the pre-edge value, so a same-cycle pop does not make room.
    always_comb begin
        w_push_req = (w_state == W_ACK) && w_in_map && (w_reg == 4'h0);
        if (!w_in_map || w_reg != 4'h0) w_resp = RESP_DECERR;
        else if (tx_full[w_ch])         w_resp = RESP_SLVERR;
        else                            w_resp = RESP_OKAY;
    end

    // Read data/response; an empty RX read is a non-blocking SLVERR rather than a stall.
    always_comb begin
        r_pop_req   = (r_state == R_ACK) && r_in_map && (r_reg == 4'h4);
        status_word = {8'h00, 8'(rx_level[r_ch]), 8'(tx_level[r_ch]), 4'h0,
                       rx_empty[r_ch], rx_full[r_ch], tx_empty[r_ch], tx_full[r_ch]};
        r_data      = '0;
        r_resp      = RESP_DECERR;
        if (r_in_map) begin
            if (r_reg == 4'h4) begin
                if (rx_empty[r_ch]) begin
                    r_resp = RESP_SLVERR;
                end else begin
                    r_resp = RESP_OKAY;
                    r_data = rx_head[r_ch];
                end
            end else if (r_reg == 4'h8) begin
                r_resp = RESP_OKAY;
                r_data = DW'(status_word);
            end
        end
    end

    // Write and read FSM state registers plus the registered responses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            bresp_q <= 2'b00;
            rresp_q <= 2'b00;
            rdata_q <= '0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            if (w_state == W_ACK) bresp_q <= w_resp;
            if (r_state == R_ACK) begin
                rresp_q <= r_resp;
                rdata_q <= r_data;
            end
        end
    end

    // Next-state logic; both channels of the AXI-Lite bus advance independently.
    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_IDLE:  if (bus.awvalid && bus.wvalid) w_next = W_ACK;
            W_ACK:   w_next = W_RESP;
            W_RESP:  if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  if (bus.arvalid) r_next = R_ACK;
            R_ACK:   r_next = R_RESP;
            R_RESP:  if (bus.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign bus.awready = (w_state == W_ACK);
    assign bus.wready  = (w_state == W_ACK);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;
    assign bus.arready = (r_state == R_ACK);
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    assign unused_bits = ^{bus.wstrb, w_off, r_off, tx_pop, rx_pop};
endmodule

// File: doc/axis_converter_lite_mc.md
AXIS_CONVERTER_LITE_MC -- requirements
Module: axis_converter_lite_mc

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning data width of AXI-Lite and every stream channel.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning AXI-Lite address width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of channel 0 register block (16-byte aligned).
REQ-004 SHALL have parameter N_CH, default 4, range 1..16, meaning number of independent stream channel pairs.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, power of two 2..128, meaning entries per TX and per RX FIFO.
REQ-006 SHALL have ports: aclk in 1 clock; aresetn in 1 asynchronous active-low reset; one clock domain only.
REQ-007 SHALL have AXI-Lite slave ports awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp[1:0]/bvalid/bready, araddr/arvalid/arready, rdata/rresp[1:0]/rvalid/rready, widths per parameters, wstrb ignored.
REQ-008 SHALL have m_axis_tdata out N_CH*AXI_DATA_WIDTH, m_axis_tvalid out N_CH, m_axis_tready in N_CH: per-channel master streams, channel c in slice c.
REQ-009 SHALL have s_axis_tdata in N_CH*AXI_DATA_WIDTH, s_axis_tvalid in N_CH, s_axis_tready out N_CH: per-channel slave streams.

Function
REQ-010 SHALL map channel c at BASE_ADDR+16*c: +0x0 TX_DATA (write-only), +0x4 RX_DATA (read-only), +0x8 STATUS (read-only).
REQ-011 SHALL respond DECERR (2'b11) to any address outside the map, to write of RX_DATA/STATUS, to read of TX_DATA; rdata 0 on any error.
REQ-012 SHALL provide per channel a TX FIFO (AXI-Lite -> m_axis) and an RX FIFO (s_axis -> AXI-Lite), each FIFO_DEPTH deep, first-word-fall-through.
REQ-013 Write FSM states W_IDLE, W_ACK, W_RESP; W_IDLE -> W_ACK only when awvalid and wvalid both high in the same cycle.
REQ-014 In W_ACK, awready and wready SHALL be high for exactly one cycle; decode and FIFO push SHALL occur in that cycle; next state W_RESP.
REQ-015 In W_RESP, bvalid SHALL be high with bresp stable until bready; on bready -> W_IDLE, bvalid low next cycle.
REQ-016 Write to TX_DATA of a full TX FIFO SHALL be dropped with bresp SLVERR (2'b10); fullness sampled in W_ACK before same-cycle pop.
REQ-017 Read FSM states R_IDLE, R_ACK, R_RESP; R_IDLE -> R_ACK on arvalid; arready high exactly one cycle in R_ACK; rvalid in R_RESP until rready.
REQ-018 Read of RX_DATA SHALL pop one RX entry in R_ACK and return it with OKAY; read of empty RX FIFO SHALL return rdata 0, rresp SLVERR, no pop (non-blocking).
REQ-019 STATUS SHALL read: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, [15:8] tx_level, [23:16] rx_level, other bits 0; sampled in R_ACK.
REQ-020 m_axis_tvalid[c] SHALL equal TX FIFO c not empty; tdata SHALL be head entry; pop on tvalid and tready; tdata stable while tvalid and not tready.
REQ-021 s_axis_tready[c] SHALL equal RX FIFO c not full; push on tvalid and tready.
REQ-022 Simultaneous push and pop on one FIFO SHALL both take effect, level unchanged; pointers wrap modulo FIFO_DEPTH; level width clog2(FIFO_DEPTH)+1.
REQ-023 Write and read FSMs SHALL run concurrently and independently; channels SHALL not interact.
REQ-024 Latency: write to TX_DATA at W_ACK edge -> m_axis_tvalid high next cycle; s_axis beat accepted -> visible in STATUS/RX_DATA next cycle.

Reset
REQ-025 On aresetn low, asynchronously: FSMs to W_IDLE/R_IDLE, all FIFOs empty, awready/wready/arready/bvalid/rvalid 0, bresp/rresp 0, rdata 0, m_axis_tvalid 0, s_axis_tready 0.
REQ-026 s_axis_tready SHALL remain 0 until first cycle after aresetn deasserts; reset mid-transaction SHALL abandon it with no response and discard FIFO contents.

Verification
REQ-027 Write 0xA5A5_0001 to BASE+0x10 -> bresp OKAY, m_axis_tvalid[1]=1, tdata slice1=0xA5A5_0001, other channels idle.
REQ-028 FIFO_DEPTH+1 writes to ch0 TX_DATA, m_axis_tready[0]=0 -> first 8 OKAY, 9th SLVERR; STATUS ch0 = tx_full, tx_level 8.
REQ-029 Drive 3 beats 0x11,0x22,0x33 on s_axis ch2 -> three RX_DATA reads return in order OKAY; 4th read rdata 0, SLVERR.
REQ-030 Read BASE+0x0C and write BASE+16*N_CH -> DECERR each, rdata 0, no FIFO change.
REQ-031 Full TX FIFO with tready=1 and concurrent write in W_ACK -> write SLVERR, one beat popped, level 7.
REQ-032 Assert aresetn low mid-W_RESP with FIFOs non-empty -> bvalid 0 immediately, all FIFOs empty, STATUS = 0x0000_000A after reset.
